// File: rtl/nbit_accum_cpu.sv
// Parametrised two-phase accumulator CPU: FETCH latches the program word, EXEC runs it.
// Define NBIT_ACCUM_CPU_BRANCH_EN to build the zero flag and the conditional JZ branch.
module nbit_accum_cpu #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   pc,
    input  logic [DATA_W+2:0] instr,
    output logic [DATA_W-1:0] output_data,
    output logic              out_valid,
    output logic              halted
);

    typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;
    typedef enum logic [2:0] {
        OpNop, OpLdi, OpAdd, OpSub, OpOut, OpJmp, OpJz, OpHalt
    } opcode_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W+2:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;

    opcode_e             op;
    logic [DATA_W-1:0]   imm;

    assign op  = opcode_e'(ir_q[DATA_W+2:DATA_W]);
    assign imm = ir_q[DATA_W-1:0];

`ifdef NBIT_ACCUM_CPU_BRANCH_EN
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
        zero_d      = zero_q;
`endif
        unique case (state_q)
            StFetch: begin
                ir_d    = instr;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_q + PC_W'(1);
                unique case (op)
                    OpNop: ;
                    OpLdi: acc_d = imm;
                    OpAdd: acc_d = acc_q + imm;
                    OpSub: acc_d = acc_q - imm;
                    OpOut: begin
                        out_d       = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OpJmp: pc_d = imm[PC_W-1:0];
                    OpJz: begin
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
                        if (zero_q) pc_d = imm[PC_W-1:0];
`endif
                    end
                    OpHalt: begin
                        state_d = StHalt;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
                // Flag tracks only the arithmetic/load results.
                if (op == OpLdi || op == OpAdd || op == OpSub) zero_d = (acc_d == '0);
`endif
            end
            StHalt: ;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
            zero_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
            zero_q      <= zero_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign output_data = out_q;
    assign out_valid   = out_valid_q;
    assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_nbit_accum_cpu.sv
// Bench for nbit_accum_cpu: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed results.
module tb_nbit_accum_cpu;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PC_W   = 4;

    logic              clk;
    logic              reset;
    logic [PC_W-1:0]   pc;
    logic [DATA_W+2:0] instr;
    logic [DATA_W-1:0] output_data;
    logic              out_valid;
    logic              halted;

    logic [DATA_W+2:0] rom [16];
    assign instr = rom[pc];

    nbit_accum_cpu #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .instr      (instr),
        .output_data(output_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int out_vals [$];
    int out_cycs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W+2:0] enc(input int op, input int imm);
        logic [2:0]        o;
        logic [DATA_W-1:0] i;
        o = op[2:0];
        i = imm[DATA_W-1:0];
        return {o, i};
    endfunction

    // Reference model: one instruction per two cycles, state predicted for the next edge.
    logic [PC_W-1:0]   m_pc;
    logic [DATA_W-1:0] m_acc, m_out;
    logic              m_zf, m_valid, m_halt, m_exec;
    logic [DATA_W+2:0] m_ir;

    task automatic model_reset();
        m_pc = '0; m_acc = '0; m_out = '0; m_zf = 1'b1;
        m_valid = 1'b0; m_halt = 1'b0; m_exec = 1'b0; m_ir = '0;
    endtask

    task automatic model_step();
        int op;
        int imm;
        if (m_halt) begin
            m_valid = 1'b0;
        end else if (!m_exec) begin
            m_ir    = rom[m_pc];
            m_exec  = 1'b1;
            m_valid = 1'b0;
        end else begin
            op      = int'(m_ir[DATA_W+2:DATA_W]);
            imm     = int'(m_ir[DATA_W-1:0]);
            m_exec  = 1'b0;
            m_valid = 1'b0;
            case (op)
                1: begin m_acc = DATA_W'(imm); m_zf = (m_acc == 0); end
                2: begin m_acc = DATA_W'((int'(m_acc) + imm) % 256); m_zf = (m_acc == 0); end
                3: begin m_acc = DATA_W'((int'(m_acc) - imm + 256) % 256); m_zf = (m_acc == 0); end
                4: begin m_out = m_acc; m_valid = 1'b1; end
                default: ;
            endcase
            if (op == 7) m_halt = 1'b1;
            else if (op == 5) m_pc = PC_W'(imm % 16);
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
            else if (op == 6 && m_zf) m_pc = PC_W'(imm % 16);
`endif
            else m_pc = PC_W'((int'(m_pc) + 1) % 16);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!reset) model_reset();
        chk("model_pc", 32'(pc), 32'(m_pc));
        chk("model_output_data", 32'(output_data), 32'(m_out));
        chk("model_out_valid", 32'(out_valid), 32'(m_valid));
        chk("model_halted", 32'(halted), 32'(m_halt));
        if (out_valid === 1'b1) begin
            out_vals.push_back(int'(output_data));
            out_cycs.push_back(cyc);
        end
        if (reset) model_step();
    end

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = '0;
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_pc"}, 32'(pc), 0);
        chk({name, "_out"}, 32'(output_data), 0);
        chk({name, "_valid"}, 32'(out_valid), 0);
        chk({name, "_halted"}, 32'(halted), 0);
    endtask

    // Called at posedge+2; release also lands at posedge+2.
    task automatic restart(input int hold);
        reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        repeat (hold) @(posedge clk);
        #2;
        out_vals.delete();
        out_cycs.delete();
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int budget, input string name);
        int n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(name, 32'(halted), 1);
    endtask

    initial begin
        reset = 1'b1;
        clear_rom();
        #1 reset = 1'b0;

        // Arithmetic wrap with 10-cycle reset
        rom[0] = enc(1, 250); rom[1] = enc(2, 10); rom[2] = enc(4, 0); rom[3] = enc(7, 0);
        repeat (10) @(posedge clk);
        #2;
        check_reset_vals("rst_hold");
        out_vals.delete(); out_cycs.delete();
        reset = 1'b1;
        @(posedge clk); #2;
        chk("pc_after_1", 32'(pc), 0);
        @(posedge clk); #2;
        chk("pc_after_2", 32'(pc), 1);
        wait_halt(40, "wrap_halt");
        chk("wrap_out", 32'(output_data), 4);
        chk("wrap_pc", 32'(pc), 3);
        chk("wrap_pulses", 32'(out_vals.size()), 1);
        @(posedge clk); #2;
        chk("wrap_valid_in_halt", 32'(out_valid), 0);
        chk("wrap_pc_frozen", 32'(pc), 3);

        // Reset during HALT, then rerun
        restart(2);
        wait_halt(40, "rerun_halt");
        chk("rerun_pulses", 32'(out_vals.size()), 1);
        if (out_vals.size() >= 1) chk("rerun_out", 32'(out_vals[0]), 4);

        // Countdown loop
        clear_rom();
        rom[0] = enc(1, 3); rom[1] = enc(4, 0); rom[2] = enc(3, 1);
        rom[3] = enc(6, 5); rom[4] = enc(5, 1); rom[5] = enc(7, 0);
        restart(2);
`ifdef NBIT_ACCUM_CPU_BRANCH_EN
        wait_halt(200, "count_halt");
        chk("count_pulses", 32'(out_vals.size()), 3);
        chk("count_pc", 32'(pc), 5);
        if (out_vals.size() >= 3) begin
            chk("count_v0", 32'(out_vals[0]), 3);
            chk("count_v1", 32'(out_vals[1]), 2);
            chk("count_v2", 32'(out_vals[2]), 1);
        end
`else
        repeat (120) @(posedge clk);
        #2;
        chk("count_not_halted", 32'(halted), 0);
        chk("count_enough", 32'(out_vals.size() >= 5), 1);
        if (out_vals.size() >= 5) begin
            chk("count_v0", 32'(out_vals[0]), 3);
            chk("count_v1", 32'(out_vals[1]), 2);
            chk("count_v2", 32'(out_vals[2]), 1);
            chk("count_v3", 32'(out_vals[3]), 0);
            chk("count_v4", 32'(out_vals[4]), 255);
        end
`endif

        // PC wraparound over all-NOP memory
        clear_rom();
        restart(2);
        repeat (31) @(posedge clk);
        #2;
        chk("nop_pc15", 32'(pc), 15);
        @(posedge clk); #2;
        chk("nop_pc_wrap", 32'(pc), 0);
        chk("nop_not_halted", 32'(halted), 0);

        // Back-to-back OUT, with a reset during the second OUT's EXEC
        clear_rom();
        rom[0] = enc(1, 7); rom[1] = enc(4, 0); rom[2] = enc(4, 0); rom[3] = enc(7, 0);
        restart(2);
        repeat (5) @(posedge clk);
        #2;
        chk("b2b_mid_out", 32'(output_data), 7);
        chk("b2b_mid_pc", 32'(pc), 2);
        restart(3);
        wait_halt(40, "b2b_halt");
        chk("b2b_pulses", 32'(out_vals.size()), 2);
        if (out_vals.size() >= 2) begin
            chk("b2b_v0", 32'(out_vals[0]), 7);
            chk("b2b_v1", 32'(out_vals[1]), 7);
            chk("b2b_gap", 32'(out_cycs[1] - out_cycs[0]), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbit_accum_cpu.md
# nbit_accum_cpu

Parametrised accumulator CPU, the successor to the 2-bit computer: configurable data and program-counter widths, an 8-opcode instruction set, a two-phase fetch/execute state machine, a zero flag with conditional branch, and a halt state. Instructions come from an external program memory addressed by `pc`. Results leave through a registered `output_data` port with a one-cycle `out_valid` strobe. The block sits at the top of the computer next to the program ROM; the testbench drives only clock and reset.

## Interface
- `DATA_W`, 8, accumulator, immediate and `output_data` width; must be ≥ `PC_W`.
- `PC_W`, 4, program-counter width; program space is 2^`PC_W` words.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- `pc`  output  `PC_W`  address of the instruction to fetch.
- `instr`  input  `DATA_W`+3  program word: `[DATA_W+2:DATA_W]` opcode, `[DATA_W-1:0]` immediate; sampled in FETCH.
- `output_data`  output  `DATA_W`  last value written by OUT.
- `out_valid`  output  1  high for one cycle after each OUT.
- `halted`  output  1  high while in HALT.

## Operation
- **Reset values:** `pc`=0, accumulator=0, zero flag=1, `output_data`=0, `out_valid`=0, `halted`=0, state FETCH.
- **State machine:**
  - FETCH: load `instr` into the instruction register; go to EXEC.
  - EXEC: execute the instruction; go to FETCH, or to HALT for HALT.
  - HALT: hold all state; only `reset` leaves HALT.
- **Opcodes:**
  - 000 NOP.
  - 001 LDI: acc=imm.
  - 010 ADD: acc=acc+imm, mod 2^`DATA_W`, carry discarded.
  - 011 SUB: acc=acc−imm, mod 2^`DATA_W`.
  - 100 OUT: `output_data`=acc.
  - 101 JMP: `pc`=imm[`PC_W`-1:0].
  - 110 JZ: if zero flag then `pc`=imm[`PC_W`-1:0].
  - 111 HALT.
- **Zero flag:** updated only by LDI/ADD/SUB, to (new acc == 0). All other opcodes leave it unchanged.
- **PC update:** the non-jump default is `pc`+1 mod 2^`PC_W`; 2^`PC_W`−1 wraps to 0. A not-taken JZ also increments. HALT does not increment.
- **Unused immediate bits** are ignored. Jump targets use the low `PC_W` bits only.

## Timing
- Every instruction takes exactly 2 cycles: FETCH then EXEC. No stalls, no pipelining.
- `instr` must be valid combinationally from `pc` within the FETCH cycle.
- Acc, flag and `pc` update on the EXEC clock edge. A new `pc` is visible in the following FETCH cycle.
- OUT:
  - `output_data` changes on the EXEC edge.
  - `out_valid` is 1 for exactly the next cycle, which is FETCH of the following instruction, then returns to 0.
  - Back-to-back OUTs give pulses 2 cycles apart.
- HALT: `halted` rises on the EXEC edge and stays high. `out_valid` is 0 in HALT.
- Reset mid-instruction, including during EXEC or HALT: all outputs return to their reset values asynchronously. Execution restarts with FETCH at `pc`=0 on the first rising edge after `reset` goes high.

## Configuration
- `NBIT_ACCUM_CPU_BRANCH_EN` defined: JZ is the conditional branch described above.
- Not defined:
  - The zero-flag and branch logic is omitted; JZ executes as NOP (`pc`+1).
  - `halted` and every other behaviour are unchanged.

## Test plan
All scenarios use `DATA_W`=8, `PC_W`=4.
- **Reset:** hold `reset`=0 for 10 cycles, then release → `pc`=0, `output_data`=0, `out_valid`=0, `halted`=0 during reset; first `pc` change to 1 occurs 2 cycles after release.
- **Arithmetic wrap:** program LDI 250, ADD 10, OUT, HALT → `output_data`=4, one `out_valid` pulse, then `halted`=1 with `pc` frozen at 3.
- **Countdown loop:** program LDI 3, OUT, SUB 1, JZ 5, JMP 1, HALT at address 5 → outputs 3, 2, 1 on successive pulses, then `halted`=1. Without the macro, JZ falls through and the loop repeats after the SUB underflow (255, 254, …).
- **PC wraparound:** NOP at all 16 addresses → `pc` steps 0..15, then 0 again, one step every 2 cycles; `halted` stays 0.
- **Reset during HALT and during EXEC:** assert `reset` in each case → immediate return to the reset values; the program reruns from address 0 with identical outputs.
- **Back-to-back OUT:** program LDI 7, OUT, OUT, HALT → two `out_valid` pulses exactly 2 cycles apart, both with `output_data`=7.
